// File: rtl/cpu_pkg.sv
// Shared definitions for the small CPU: opcodes, ALU function codes, PC control
// codes, controller state encoding and the decoded-instruction record.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_MVI  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_OR     = 3'b011,
    ALU_PASS_B = 3'b100
  } alu_func_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_LOAD = 2'b10
  } pc_ctrl_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_WB,
    S_PCUPD,
    S_HALT
  } state_e;

  typedef struct packed {
    alu_func_e alu_func;
    logic      alu_in_sel;
    logic      is_alu;
    logic      wr;
    logic      jmp;
    logic      jz;
    logic      halt;
    logic      illegal;
  } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: ALU function/operand select plus the
// instruction class bits the controller FSM branches on.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o          = '0;
    dec_o.alu_func = ALU_ADD;
    case (opcode_i)
      OP_NOP:  ;
      OP_MOV:  begin dec_o.alu_func = ALU_PASS_B; dec_o.is_alu = 1'b1; dec_o.wr = 1'b1; end
      OP_ADD:  begin dec_o.alu_func = ALU_ADD;    dec_o.is_alu = 1'b1; dec_o.wr = 1'b1; end
      OP_SUB:  begin dec_o.alu_func = ALU_SUB;    dec_o.is_alu = 1'b1; dec_o.wr = 1'b1; end
      OP_AND:  begin dec_o.alu_func = ALU_AND;    dec_o.is_alu = 1'b1; dec_o.wr = 1'b1; end
      OP_OR:   begin dec_o.alu_func = ALU_OR;     dec_o.is_alu = 1'b1; dec_o.wr = 1'b1; end
      OP_ADDI: begin
        dec_o.alu_func   = ALU_ADD;
        dec_o.alu_in_sel = 1'b1;
        dec_o.is_alu     = 1'b1;
        dec_o.wr         = 1'b1;
      end
      OP_MVI:  begin
        dec_o.alu_func   = ALU_PASS_B;
        dec_o.alu_in_sel = 1'b1;
        dec_o.is_alu     = 1'b1;
        dec_o.wr         = 1'b1;
      end
      // CMP runs the ALU for the zero flag only; nothing is written back
      OP_CMP:  begin dec_o.alu_func = ALU_SUB; dec_o.is_alu = 1'b1; end
      OP_JMP:  dec_o.jmp  = 1'b1;
      OP_JZ:   dec_o.jz   = 1'b1;
      OP_HALT: dec_o.halt = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle controller: fetches an instruction, sequences the data_path
// operand/ALU chain, register write-back and the PC update.
module ctrl_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        en_out,
  input  logic        z_out,
  output logic        en_in,
  output logic [3:0]  reg_en,
  output logic [1:0]  rd,
  output logic [1:0]  rs,
  output logic        alu_in_sel,
  output logic [2:0]  alu_func,
  output logic [7:0]  offset,
  output logic [7:0]  offset_addr,
  output logic        en_pc_pulse,
  output logic [1:0]  pc_ctrl,
  output logic        halted,
  output logic        err
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        jump_q, jump_d;
  logic        err_q, err_d;
  dec_t        dec;

  // Decoding ir_q keeps every field stable from DECODE until the next FETCH.
  instr_decode u_dec (
    .opcode_i (ir_q[15:12]),
    .dec_o    (dec)
  );

  assign rd          = ir_q[11:10];
  assign rs          = ir_q[9:8];
  assign offset      = ir_q[7:0];
  assign offset_addr = ir_q[7:0];
  assign alu_func    = dec.alu_func;
  assign alu_in_sel  = dec.alu_in_sel;
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      wcnt_q  <= '0;
      jump_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wcnt_q  <= wcnt_d;
      jump_q  <= jump_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    wcnt_d      = wcnt_q;
    jump_d      = jump_q;
    err_d       = err_q;
    en_in       = 1'b0;
    reg_en      = '0;
    en_pc_pulse = 1'b0;
    pc_ctrl     = PC_HOLD;
    halted      = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = ir;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // z_out is only looked at here, so JZ sees the last ALU/CMP result
        jump_d = dec.jmp | (dec.jz & z_out);
        if (dec.illegal) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else if (dec.halt) begin
          state_d = S_HALT;
        end else if (dec.is_alu) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_PCUPD;
        end
      end
      S_EXEC: begin
        en_in   = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (en_out) begin
          state_d = S_WB;
        end else if (wcnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_WB: begin
        if (dec.wr) reg_en = 4'b0001 << rd;
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        en_pc_pulse = 1'b1;
        pc_ctrl     = jump_q ? PC_LOAD : PC_INC;
        state_d     = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: a vector table of instructions run back to back,
// plus hand-written timeout, halt/illegal and reset-mid-WAIT sequences.
module tb_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst, start, en_out, z_out;
  logic [15:0] ir;
  logic        en_in, alu_in_sel, en_pc_pulse, halted, err;
  logic [3:0]  reg_en;
  logic [1:0]  rd, rs, pc_ctrl;
  logic [2:0]  alu_func;
  logic [7:0]  offset, offset_addr;

  int checks = 0;
  int errors = 0;

  ctrl_unit #(.WAIT_MAX(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ir          (ir),
    .en_out      (en_out),
    .z_out       (z_out),
    .en_in       (en_in),
    .reg_en      (reg_en),
    .rd          (rd),
    .rs          (rs),
    .alu_in_sel  (alu_in_sel),
    .alu_func    (alu_func),
    .offset      (offset),
    .offset_addr (offset_addr),
    .en_pc_pulse (en_pc_pulse),
    .pc_ctrl     (pc_ctrl),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic        z;
    int          w;
    logic [2:0]  func;
    logic        sel;
    logic [3:0]  reg_en;
    logic [1:0]  pc;
    int          lat;
    int          n_en_in;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {30'd0, en_in, reg_en, rd, rs, alu_in_sel, alu_func, offset, offset_addr,
            en_pc_pulse, pc_ctrl, halted, err};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; en_out = 1'b0; z_out = 1'b0; ir = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one instruction starting from its FETCH cycle; returns at the PCUPD cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int   cyc = 0, en_in_cnt = 0, en_in_cyc = -1, reg_cnt = 0, lat = -1;
    logic [3:0] reg_seen = '0;
    logic [1:0] pc_seen = 2'b11;
    bit   done = 1'b0, fields_ok = 1'b1, pc_quiet = 1'b1, status_ok = 1'b1;
    string tag;
    tag = $sformatf("vec%0d_ir%04h", idx, v.ir);
    ir = v.ir;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (en_in) begin en_in_cnt++; en_in_cyc = cyc; end
      if (reg_en != 4'b0000) begin reg_cnt++; reg_seen |= reg_en; end
      if (cyc >= 2 && (rd !== v.ir[11:10] || rs !== v.ir[9:8] || offset !== v.ir[7:0] ||
                       offset_addr !== v.ir[7:0] || alu_func !== v.func || alu_in_sel !== v.sel))
        fields_ok = 1'b0;
      if (halted || err) status_ok = 1'b0;
      if (en_pc_pulse) begin
        done = 1'b1; lat = cyc; pc_seen = pc_ctrl;
      end else if (pc_ctrl != 2'b00) begin
        pc_quiet = 1'b0;
      end
      // z_out valid only in DECODE; stray en_out in EXEC and a stray start
      start  = (cyc == 2);
      z_out  = (cyc == 2) ? v.z : ~v.z;
      en_out = (cyc == 3) || (en_in_cyc > 0 && cyc == en_in_cyc + v.w);
    end
    start = 1'b0; en_out = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
    chk({tag, "_en_in_count"}, 64'(en_in_cnt), 64'(v.n_en_in));
    chk({tag, "_reg_en"}, 64'(reg_seen), 64'(v.reg_en));
    chk({tag, "_reg_en_cycles"}, 64'(reg_cnt), (v.reg_en != 4'b0000) ? 64'd1 : 64'd0);
    chk({tag, "_pc_ctrl"}, 64'(pc_seen), 64'(v.pc));
    chk({tag, "_fields_stable"}, 64'(fields_ok), 64'd1);
    chk({tag, "_pc_ctrl_quiet"}, 64'(pc_quiet), 64'd1);
    chk({tag, "_no_halt_err"}, 64'(status_ok), 64'd1);
  endtask

  initial begin
    int cyc, n_en_in, n_reg, n_pc;

    vecs[0]  = '{16'h6405, 1'b0, 2,  3'b000, 1'b1, 4'b0010, 2'b01, 7,  1}; // ADDI
    vecs[1]  = '{16'h8100, 1'b0, 1,  3'b001, 1'b0, 4'b0000, 2'b01, 6,  1}; // CMP
    vecs[2]  = '{16'hA030, 1'b1, 0,  3'b000, 1'b0, 4'b0000, 2'b10, 3,  0}; // JZ taken
    vecs[3]  = '{16'h8100, 1'b0, 3,  3'b001, 1'b0, 4'b0000, 2'b01, 8,  1}; // CMP
    vecs[4]  = '{16'hA030, 1'b0, 0,  3'b000, 1'b0, 4'b0000, 2'b01, 3,  0}; // JZ not taken
    vecs[5]  = '{16'h0000, 1'b1, 0,  3'b000, 1'b0, 4'b0000, 2'b01, 3,  0}; // NOP
    vecs[6]  = '{16'h9055, 1'b0, 0,  3'b000, 1'b0, 4'b0000, 2'b10, 3,  0}; // JMP
    vecs[7]  = '{16'h1E00, 1'b0, 1,  3'b100, 1'b0, 4'b1000, 2'b01, 6,  1}; // MOV r3,r2
    vecs[8]  = '{16'h2900, 1'b0, 4,  3'b000, 1'b0, 4'b0100, 2'b01, 9,  1}; // ADD r2,r1
    vecs[9]  = '{16'h3300, 1'b0, 1,  3'b001, 1'b0, 4'b0001, 2'b01, 6,  1}; // SUB r0,r3
    vecs[10] = '{16'h4600, 1'b0, 2,  3'b010, 1'b0, 4'b0010, 2'b01, 7,  1}; // AND r1,r2
    vecs[11] = '{16'h5B00, 1'b0, 1,  3'b011, 1'b0, 4'b0100, 2'b01, 6,  1}; // OR r2,r3
    vecs[12] = '{16'h7CAA, 1'b0, 1,  3'b100, 1'b1, 4'b1000, 2'b01, 6,  1}; // MVI r3
    vecs[13] = '{16'h2D00, 1'b0, 15, 3'b000, 1'b0, 4'b1000, 2'b01, 20, 1}; // ADD, last WAIT

    do_reset();
    chk("reset_outputs", all_outs(), 64'd0);

    start = 1'b1;
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Timeout: en_out never comes; HALT follows the 15th WAIT cycle
    do_reset();
    ir = 16'h2500; start = 1'b1;
    cyc = 0; n_en_in = 0; n_reg = 0; n_pc = 0;
    while (cyc < 26) begin
      @(negedge clk);
      cyc++;
      start  = (cyc == 21);
      en_out = 1'b0;
      if (en_in) n_en_in++;
      if (reg_en != 4'b0000) n_reg++;
      if (en_pc_pulse) n_pc++;
      if (cyc == 18) chk("timeout_not_yet_halted", 64'(halted), 64'd0);
      if (cyc == 19) begin
        chk("timeout_halted", 64'(halted), 64'd1);
        chk("timeout_err", 64'(err), 64'd1);
      end
    end
    chk("timeout_still_halted", 64'(halted), 64'd1);
    chk("timeout_en_in_count", 64'(n_en_in), 64'd1);
    chk("timeout_no_reg_en", 64'(n_reg), 64'd0);
    chk("timeout_no_pc_pulse", 64'(n_pc), 64'd0);

    // Illegal opcode
    do_reset();
    ir = 16'hC000; start = 1'b1;
    cyc = 0; n_en_in = 0;
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (en_in) n_en_in++;
      if (cyc == 2) chk("illegal_decode_not_halted", 64'(halted), 64'd0);
      if (cyc == 3) begin
        chk("illegal_halted", 64'(halted), 64'd1);
        chk("illegal_err", 64'(err), 64'd1);
      end
    end
    chk("illegal_no_en_in", 64'(n_en_in), 64'd0);

    // HALT instruction, then start is ignored
    do_reset();
    ir = 16'hF000; start = 1'b1;
    cyc = 0; n_en_in = 0; n_pc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 4);
      if (cyc >= 3) ir = 16'h0000;
      if (en_in) n_en_in++;
      if (en_pc_pulse) n_pc++;
      if (cyc == 3) begin
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_err", 64'(err), 64'd0);
      end
    end
    chk("halt_after_start_halted", 64'(halted), 64'd1);
    chk("halt_after_start_err", 64'(err), 64'd0);
    chk("halt_no_activity", 64'(n_en_in + n_pc), 64'd0);

    // Reset in the middle of WAIT, then a late en_out
    do_reset();
    ir = 16'h2500; start = 1'b1;
    cyc = 0;
    while (cyc < 5) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en_out = 1'b1;
    chk("midwait_reset_outputs", all_outs(), 64'd0);
    n_en_in = 0; n_reg = 0; n_pc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      en_out = 1'b0;
      if (en_in) n_en_in++;
      if (reg_en != 4'b0000) n_reg++;
      if (en_pc_pulse) n_pc++;
    end
    chk("midwait_no_reg_en", 64'(n_reg), 64'd0);
    chk("midwait_no_pc_pulse", 64'(n_pc), 64'd0);
    chk("midwait_no_en_in", 64'(n_en_in), 64'd0);
    chk("midwait_idle_outputs", all_outs(), 64'd0);

    // Back in IDLE: a NOP must complete normally from a fresh start
    ir = 16'h0000; start = 1'b1;
    cyc = 0; n_pc = 0;
    while (cyc < 3) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (en_pc_pulse) n_pc = cyc;
    end
    chk("midwait_restart_nop_pcupd_cycle", 64'(n_pc), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 Parameter WAIT_MAX, default 15, SHALL set the maximum cycles spent waiting for en_out before a timeout.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; leaves IDLE.
REQ-005 ir  in  16  instruction word from instruction ROM addressed by data_path pc_out.
REQ-006 en_out  in  1  data_path ALU result-valid pulse.
REQ-007 z_out  in  1  data_path zero flag.
REQ-008 en_in  out  1  one-cycle pulse that starts the data_path operand/ALU chain.
REQ-009 reg_en  out  4  one-hot register write enable.
REQ-010 rd, rs  out  2 each  register selects.
REQ-011 alu_in_sel  out  1  0 = rs operand, 1 = offset operand.
REQ-012 alu_func  out  3  ALU operation code.
REQ-013 offset, offset_addr  out  8 each  immediate and jump target.
REQ-014 en_pc_pulse  out  1  one-cycle PC update strobe.
REQ-015 pc_ctrl  out  2  00 hold, 01 increment, 10 load offset_addr, 11 hold.
REQ-016 halted, err  out  1 each  sticky status.

Function
REQ-017 Field layout SHALL be: ir[15:12] opcode, ir[11:10] rd, ir[9:8] rs, ir[7:0] imm.
REQ-018 Opcodes SHALL be: 0 NOP, 1 MOV (PASS_B, sel 0), 2 ADD, 3 SUB, 4 AND, 5 OR, 6 ADDI (ADD, sel 1), 7 MVI (PASS_B, sel 1), 8 CMP (SUB, no write), 9 JMP, A JZ, F HALT, B–E illegal.
REQ-019 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WAIT, WB, PCUPD and HALT.
REQ-020 IDLE SHALL go to FETCH on start; start in any other state SHALL be ignored.
REQ-021 FETCH SHALL latch ir into an internal ir_q, then go to DECODE.
REQ-022 DECODE SHALL branch as follows: ALU ops and CMP to EXEC; NOP, JMP and JZ to PCUPD; HALT to HALT; illegal opcodes to HALT with err set.
REQ-023 EXEC SHALL assert en_in for exactly one cycle, then go to WAIT.
REQ-024 WAIT SHALL go to WB on en_out=1, and to HALT with err=1 after WAIT_MAX cycles without en_out.
REQ-025 WB SHALL assert reg_en = one-hot(rd) for exactly one cycle (all zero for CMP), then go to PCUPD.
REQ-026 PCUPD SHALL assert en_pc_pulse for one cycle with pc_ctrl as follows: 10 for JMP; 10 for JZ when z_out=1; 01 otherwise. It then goes to FETCH.
REQ-027 JZ SHALL sample z_out in DECODE, so the flag comes from the most recent ALU or CMP instruction.
REQ-028 rd, rs, offset, offset_addr, alu_func and alu_in_sel SHALL be registered from ir_q and held stable from DECODE until the next FETCH.
REQ-029 Latency SHALL be 3 cycles for NOP, JMP and JZ, and 5 + W cycles for ALU ops and CMP, where W ≥ 1 is the number of WAIT cycles.
REQ-030 en_out outside WAIT SHALL be ignored, and z_out outside DECODE SHALL be ignored.
REQ-031 HALT SHALL be terminal: halted=1, all strobes 0, exit only by rst.
REQ-032 The WAIT counter SHALL be 4 bits wide, cleared on entry to WAIT, with no wrap-around.

Reset
REQ-033 On rst, state SHALL go to IDLE, and ir_q, the WAIT counter, all outputs, halted and err SHALL all go to 0.
REQ-034 rst in any state, including mid-WAIT, SHALL abort the instruction with no reg_en or en_pc_pulse afterwards.

Structure
REQ-035 Shared package cpu_pkg SHALL hold the opcode constants, the alu_func codes (ADD 000, SUB 001, AND 010, OR 011, PASS_B 100), the pc_ctrl codes and the state encoding, and SHALL be used by both alu and ctrl_unit.
REQ-036 One sub-module, instr_decode (combinational: opcode to alu_func, alu_in_sel, write/jump/halt/illegal class), SHALL exist; the FSM SHALL stay in ctrl_unit.

Verification
REQ-037 ADDI: rst, start, ir=0x6405, en_out 2 cycles after en_in -> alu_func=000, alu_in_sel=1, offset=0x05, reg_en=0010 for one cycle, then en_pc_pulse with pc_ctrl=01.
REQ-038 JZ taken and not taken: CMP ir=0x8100 then JZ ir=0xA030 with z_out=1 -> pc_ctrl=10, offset_addr=0x30; repeat with z_out=0 -> pc_ctrl=01.
REQ-039 CMP: ir=0x8100 -> en_in pulses, reg_en stays 0000, PC increments.
REQ-040 Timeout: ALU op with en_out never asserted -> after 15 WAIT cycles, halted=1, err=1, no reg_en.
REQ-041 Illegal and HALT: ir=0xC000 -> halted=1, err=1; ir=0xF000 -> halted=1, err=0; start afterwards is ignored.
REQ-042 Reset mid-WAIT, then en_out pulse -> state IDLE, all outputs 0, no reg_en pulse.
